mem_bank_arb: RTL and testbench
===============================

MEM_BANK_ARB -- requirements
Module: mem_bank_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning consecutive lost conflicts after which fetch wins a conflict.
REQ-002 SHALL have iw_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have iw_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have iw_if_req, input, 1: fetch read request, held until granted.
REQ-005 SHALL have iw_if_addr, input, `SIZE_ADDR: fetch address.
REQ-006 SHALL have ow_if_gnt, output, 1: fetch request accepted this cycle.
REQ-007 SHALL have ow_if_rvalid / ow_if_rdata, output, 1 / `SIZE_DATA: fetch read response.
REQ-008 SHALL have iw_ma_req, iw_ma_we, input, 1 each: memory-access request, write when we=1.
REQ-009 SHALL have iw_ma_addr / iw_ma_wdata, input, `SIZE_ADDR / `SIZE_DATA: MA address and store data.
REQ-010 SHALL have ow_ma_gnt, ow_ma_rvalid, output, 1 each; ow_ma_rdata, output, `SIZE_DATA: MA grant and load response.
REQ-011 SHALL have ow_mem_en, ow_mem_we, output, unpacked array [0:1] of 1 bit: per-bank enable and write.
REQ-012 SHALL have ow_mem_addr / ow_mem_wdata, output, unpacked array [0:1] of `SIZE_ADDR / `SIZE_DATA: per-bank command.
REQ-013 SHALL have iw_mem_rdata, input, unpacked array [0:1] of `SIZE_DATA: bank read data, valid one cycle after enable.

Function
REQ-014 Bank of a request SHALL be addr[0]; full address SHALL be forwarded unchanged on ow_mem_addr[bank].
REQ-015 Grant SHALL be combinational in the request cycle; bank command outputs SHALL be driven in the same cycle as the grant.
REQ-016 Requests to different banks, or a single request, SHALL both be granted in the same cycle.
REQ-017 Same-bank conflict: MA SHALL win unless r_if_wait == STARVE_MAX, in which case fetch SHALL win.
REQ-018 r_if_wait SHALL increment when iw_if_req && !ow_if_gnt, saturate at STARVE_MAX, and clear on ow_if_gnt or !iw_if_req.
REQ-019 Ungranted bank SHALL have ow_mem_en=0, ow_mem_we=0; addr/wdata on idle banks are don't-care but SHALL be 0.
REQ-020 Granted fetch SHALL drive we=0; granted MA SHALL drive we=iw_ma_we and wdata=iw_ma_wdata.
REQ-021 Granted read SHALL register (valid, bank) per requester; next cycle rvalid=1 and rdata=iw_mem_rdata[registered bank].
REQ-022 Granted MA write SHALL produce no ow_ma_rvalid; rvalid SHALL be a single-cycle pulse per granted read.
REQ-023 rdata SHALL be 0 when the matching rvalid is 0.
REQ-024 Back-to-back grants every cycle SHALL be supported; response registers SHALL reload each cycle without bubble.
REQ-025 No combinational path from iw_mem_rdata to any grant or command output.

Reset
REQ-026 While iw_rst=1 at a clock edge, r_if_wait, both response valids and banks SHALL clear to 0.
REQ-027 During iw_rst=1 all grants, ow_mem_en and ow_mem_we SHALL be forced 0 regardless of requests.
REQ-028 A read granted the cycle before reset asserts SHALL NOT produce rvalid; in-flight responses are discarded.

Configuration
REQ-029 Macro MEM_BANK_ARB_STARVE_EN SHALL compile in r_if_wait and the REQ-017 fetch override.
REQ-030 Without MEM_BANK_ARB_STARVE_EN, MA SHALL always win same-bank conflicts and STARVE_MAX SHALL be unused.

Verification
REQ-031 if_req addr 0x10, ma_req load addr 0x21 same cycle -> both gnt, en=2'b11, both rvalid next cycle with bank0/bank1 data.
REQ-032 if addr 0x10, ma store 0x12 wdata 0xAB -> ma_gnt=1, if_gnt=0, bank0 we=1 wdata 0xAB, no ma_rvalid.
REQ-033 STARVE_EN, continuous same-bank conflict -> if_gnt low 3 cycles, high 4th; MA stalled 4th; counter clears.
REQ-034 Without STARVE_EN, same stimulus 10 cycles -> if_gnt never asserted, ma_gnt every cycle.
REQ-035 Fetch read granted at cycle N, iw_rst=1 at cycle N+1 -> ow_if_rvalid stays 0, all outputs 0.
REQ-036 Fetch reads every cycle to alternating banks -> if_gnt continuous, rvalid continuous, rdata tracks bank order.

Source files
------------

// File: rtl/mem_bank_arb.sv
// Two-requester (fetch / memory-access) arbiter onto two address-interleaved memory banks.
// Optional fetch anti-starvation override compiled in with MEM_BANK_ARB_STARVE_EN.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module mem_bank_arb #(
    parameter int STARVE_MAX = 3
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_if_req,
    input  logic [`SIZE_ADDR-1:0] iw_if_addr,
    output logic                  ow_if_gnt,
    output logic                  ow_if_rvalid,
    output logic [`SIZE_DATA-1:0] ow_if_rdata,
    input  logic                  iw_ma_req,
    input  logic                  iw_ma_we,
    input  logic [`SIZE_ADDR-1:0] iw_ma_addr,
    input  logic [`SIZE_DATA-1:0] iw_ma_wdata,
    output logic                  ow_ma_gnt,
    output logic                  ow_ma_rvalid,
    output logic [`SIZE_DATA-1:0] ow_ma_rdata,
    output logic                  ow_mem_en    [0:1],
    output logic                  ow_mem_we    [0:1],
    output logic [`SIZE_ADDR-1:0] ow_mem_addr  [0:1],
    output logic [`SIZE_DATA-1:0] ow_mem_wdata [0:1],
    input  logic [`SIZE_DATA-1:0] iw_mem_rdata [0:1]
);

    logic if_bank;
    logic ma_bank;
    logic conflict;
    logic if_wins;

    logic if_rvalid_q, if_rvalid_d;
    logic if_bank_q,   if_bank_d;
    logic ma_rvalid_q, ma_rvalid_d;
    logic ma_bank_q,   ma_bank_d;

    assign if_bank  = iw_if_addr[0];
    assign ma_bank  = iw_ma_addr[0];
    assign conflict = iw_if_req && iw_ma_req && (if_bank == ma_bank);

`ifdef MEM_BANK_ARB_STARVE_EN
    localparam int WAIT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

    logic [WAIT_W-1:0] r_if_wait_q, r_if_wait_d;

    assign if_wins = conflict && (r_if_wait_q == WAIT_MAX);

    // Count consecutive cycles the fetch request is held but not accepted.
    always_comb begin
        r_if_wait_d = r_if_wait_q;
        if (!iw_if_req || ow_if_gnt) begin
            r_if_wait_d = '0;
        end else if (r_if_wait_q != WAIT_MAX) begin
            r_if_wait_d = r_if_wait_q + 1'b1;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_if_wait_q <= '0;
        end else begin
            r_if_wait_q <= r_if_wait_d;
        end
    end
`else
    assign if_wins = 1'b0;
`endif

    assign ow_if_gnt = !iw_rst && iw_if_req && (!conflict || if_wins);
    assign ow_ma_gnt = !iw_rst && iw_ma_req && (!conflict || !if_wins);

    // Both grants only coexist on different banks, so the two writes never overlap.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            ow_mem_en[b]    = 1'b0;
            ow_mem_we[b]    = 1'b0;
            ow_mem_addr[b]  = '0;
            ow_mem_wdata[b] = '0;
        end
        if (ow_if_gnt) begin
            ow_mem_en[if_bank]   = 1'b1;
            ow_mem_addr[if_bank] = iw_if_addr;
        end
        if (ow_ma_gnt) begin
            ow_mem_en[ma_bank]    = 1'b1;
            ow_mem_we[ma_bank]    = iw_ma_we;
            ow_mem_addr[ma_bank]  = iw_ma_addr;
            ow_mem_wdata[ma_bank] = iw_ma_wdata;
        end
    end

    always_comb begin
        if_rvalid_d = ow_if_gnt;
        if_bank_d   = ow_if_gnt ? if_bank : 1'b0;
        ma_rvalid_d = ow_ma_gnt && !iw_ma_we;
        ma_bank_d   = ma_rvalid_d ? ma_bank : 1'b0;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            if_rvalid_q <= 1'b0;
            if_bank_q   <= 1'b0;
            ma_rvalid_q <= 1'b0;
            ma_bank_q   <= 1'b0;
        end else begin
            if_rvalid_q <= if_rvalid_d;
            if_bank_q   <= if_bank_d;
            ma_rvalid_q <= ma_rvalid_d;
            ma_bank_q   <= ma_bank_d;
        end
    end

    // Responses still in flight when reset rises are hidden for the reset cycle.
    assign ow_if_rvalid = if_rvalid_q && !iw_rst;
    assign ow_ma_rvalid = ma_rvalid_q && !iw_rst;
    assign ow_if_rdata  = ow_if_rvalid ? iw_mem_rdata[if_bank_q] : '0;
    assign ow_ma_rdata  = ow_ma_rvalid ? iw_mem_rdata[ma_bank_q] : '0;

endmodule

// File: tb/tb_mem_bank_arb.sv
// Directed self-checking bench for mem_bank_arb; expectations follow MEM_BANK_ARB_STARVE_EN.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_mem_bank_arb;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  if_req;
    logic [`SIZE_ADDR-1:0] if_addr;
    logic                  if_gnt, if_rvalid;
    logic [`SIZE_DATA-1:0] if_rdata;
    logic                  ma_req, ma_we;
    logic [`SIZE_ADDR-1:0] ma_addr;
    logic [`SIZE_DATA-1:0] ma_wdata;
    logic                  ma_gnt, ma_rvalid;
    logic [`SIZE_DATA-1:0] ma_rdata;
    logic                  mem_en    [0:1];
    logic                  mem_we    [0:1];
    logic [`SIZE_ADDR-1:0] mem_addr  [0:1];
    logic [`SIZE_DATA-1:0] mem_wdata [0:1];
    logic [`SIZE_DATA-1:0] mem_rdata [0:1];

    int errors = 0;
    int checks = 0;

    mem_bank_arb #(.STARVE_MAX(3)) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_if_req(if_req), .iw_if_addr(if_addr), .ow_if_gnt(if_gnt),
        .ow_if_rvalid(if_rvalid), .ow_if_rdata(if_rdata),
        .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
        .ow_ma_gnt(ma_gnt), .ow_ma_rvalid(ma_rvalid), .ow_ma_rdata(ma_rdata),
        .ow_mem_en(mem_en), .ow_mem_we(mem_we), .ow_mem_addr(mem_addr),
        .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic ireq, input logic [`SIZE_ADDR-1:0] iaddr,
                          input logic mreq, input logic mwe,
                          input logic [`SIZE_ADDR-1:0] maddr, input logic [`SIZE_DATA-1:0] mwd);
        if_req   = ireq;
        if_addr  = iaddr;
        ma_req   = mreq;
        ma_we    = mwe;
        ma_addr  = maddr;
        ma_wdata = mwd;
    endtask

    initial begin
        logic exp_if;
        logic prev_if;
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        mem_rdata[0] = '0;
        mem_rdata[1] = '0;
        repeat (2) @(negedge clk);

        // Requests during reset are never granted
        set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h21, '0);
        #2;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_ma_gnt", ma_gnt, 0);
        chk("rst_en0", mem_en[0], 0);
        chk("rst_en1", mem_en[1], 0);
        @(negedge clk);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ma_rvalid", ma_rvalid, 0);
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("idle_if_rvalid", if_rvalid, 0);

        // Different banks: both granted, both respond next cycle
        set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h21, '0);
        #2;
        chk("diff_if_gnt", if_gnt, 1);
        chk("diff_ma_gnt", ma_gnt, 1);
        chk("diff_en0", mem_en[0], 1);
        chk("diff_en1", mem_en[1], 1);
        chk("diff_we0", mem_we[0], 0);
        chk("diff_we1", mem_we[1], 0);
        chk("diff_addr0", mem_addr[0], 32'h10);
        chk("diff_addr1", mem_addr[1], 32'h21);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        mem_rdata[0] = 32'hD0;
        mem_rdata[1] = 32'hD1;
        #2;
        chk("diff_if_rvalid", if_rvalid, 1);
        chk("diff_if_rdata", if_rdata, 32'hD0);
        chk("diff_ma_rvalid", ma_rvalid, 1);
        chk("diff_ma_rdata", ma_rdata, 32'hD1);
        chk("idle_en0", mem_en[0], 0);
        chk("idle_addr0", mem_addr[0], 0);
        @(negedge clk);
        chk("pulse_if_rvalid", if_rvalid, 0);
        chk("pulse_if_rdata", if_rdata, 0);
        chk("pulse_ma_rvalid", ma_rvalid, 0);
        chk("pulse_ma_rdata", ma_rdata, 0);

        // Same-bank conflict with an MA store: MA wins, no load response
        set_in(1'b1, 32'h10, 1'b1, 1'b1, 32'h12, 32'hAB);
        #2;
        chk("st_ma_gnt", ma_gnt, 1);
        chk("st_if_gnt", if_gnt, 0);
        chk("st_en0", mem_en[0], 1);
        chk("st_we0", mem_we[0], 1);
        chk("st_wdata0", mem_wdata[0], 32'hAB);
        chk("st_addr0", mem_addr[0], 32'h12);
        chk("st_en1", mem_en[1], 0);
        chk("st_wdata1", mem_wdata[1], 0);
        @(negedge clk);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #2;
        chk("st_ma_rvalid", ma_rvalid, 0);
        chk("st_if_rvalid", if_rvalid, 0);
        @(negedge clk);

        // Continuous same-bank conflict for 10 cycles
        prev_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0);
            mem_rdata[0] = 32'h100 + i;
`ifdef MEM_BANK_ARB_STARVE_EN
            exp_if = ((i % 4) == 3);
`else
            exp_if = 1'b0;
`endif
            #2;
            chk($sformatf("cf_if_gnt[%0d]", i), if_gnt, exp_if);
            chk($sformatf("cf_ma_gnt[%0d]", i), ma_gnt, !exp_if);
            chk($sformatf("cf_addr0[%0d]", i), mem_addr[0], exp_if ? 32'h10 : 32'h20);
            if (i > 0) begin
                chk($sformatf("cf_if_rvalid[%0d]", i), if_rvalid, prev_if);
                chk($sformatf("cf_ma_rvalid[%0d]", i), ma_rvalid, !prev_if);
                chk($sformatf("cf_rdata[%0d]", i), prev_if ? if_rdata : ma_rdata, 32'h100 + i);
            end
            prev_if = exp_if;
            @(negedge clk);
        end
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Read granted right before reset must not respond
        set_in(1'b1, 32'h11, 1'b0, 1'b0, '0, '0);
        #2;
        chk("fl_if_gnt", if_gnt, 1);
        chk("fl_en1", mem_en[1], 1);
        @(negedge clk);
        rst = 1'b1;
        mem_rdata[1] = 32'hEE;
        #2;
        chk("fl_if_rvalid_rst", if_rvalid, 0);
        chk("fl_if_rdata_rst", if_rdata, 0);
        chk("fl_if_gnt_rst", if_gnt, 0);
        chk("fl_en1_rst", mem_en[1], 0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #2;
        chk("fl_if_rvalid_post", if_rvalid, 0);
        @(negedge clk);

        // Back-to-back fetch reads alternating banks
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 32'h40 + i, 1'b0, 1'b0, '0, '0);
            mem_rdata[0] = 32'h200 + i;
            mem_rdata[1] = 32'h300 + i;
            #2;
            chk($sformatf("bb_if_gnt[%0d]", i), if_gnt, 1);
            chk($sformatf("bb_en[%0d]", i), mem_en[i % 2], 1);
            chk($sformatf("bb_addr[%0d]", i), mem_addr[i % 2], 32'h40 + i);
            if (i > 0) begin
                chk($sformatf("bb_rvalid[%0d]", i), if_rvalid, 1);
                chk($sformatf("bb_rdata[%0d]", i), if_rdata,
                    ((i - 1) % 2 == 0) ? 32'h200 + i : 32'h300 + i);
            end
            @(negedge clk);
        end
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        mem_rdata[0] = 32'h2FF;
        mem_rdata[1] = 32'h3FF;
        #2;
        chk("bb_rvalid_last", if_rvalid, 1);
        chk("bb_rdata_last", if_rdata, 32'h3FF);
        chk("bb_ma_rvalid", ma_rvalid, 0);
        @(negedge clk);
        chk("bb_rvalid_end", if_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
